// File: rtl/alu_multicycle.sv
// alu_multicycle: FSM-sequenced ALU. AND/OR/ADD/SUB/SLT/NOR complete in 1 edge and MUL in WIDTH edges (shift-add).
// Start is sampled only in IDLE and is ignored while Busy or in DONE. All outputs are registered and held between completions.
module alu_multicycle #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Op_sel,
  input  logic [WIDTH-1:0] In_a,
  input  logic [WIDTH-1:0] In_b,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_lt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // The extra top bit of the sum is carry-out and of the difference is borrow.
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_lt       = $signed(r_a) < $signed(r_b);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLT: w_res = WIDTH'(w_lt);
      OP_NOR: w_res = ~(r_a | r_b);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op     <= Op_sel;
            r_a      <= In_a;
            r_b      <= In_b;
            r_mcand  <= {{WIDTH{1'b0}}, In_a};
            r_mplier <= In_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= (Op_sel == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_carry  <= w_c;
          r_ovf    <= w_v;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_MUL: begin
          // One multiplier bit per cycle; the last step commits straight from the adder.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
            r_carry  <= 1'b0;
            r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Result   = r_result;
  assign Zero     = r_zero;
  assign Carry    = r_carry;
  assign Overflow = r_ovf;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=6): hand-computed vectors, immediate assertions at every check.
module tb_alu_multicycle;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [2:0]   Op_sel;
  logic [W-1:0] In_a;
  logic [W-1:0] In_b;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] last_res = '0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op_sel(Op_sel), .In_a(In_a), .In_b(In_b),
    .Result(Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge N: Busy rises, Done low, Result still holds the previous value.
  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start  = 1'b1;
    Op_sel = op;
    In_a   = a;
    In_b   = b;
    tick();
    Start = 1'b0;
    chk({tag, ".busy_acc"}, Busy, 1'b1);
    chk({tag, ".done_acc"}, Done, 1'b0);
    chk({tag, ".hold_acc"}, Result, last_res);
  endtask

  // Completion edge then DONE->IDLE edge.
  task automatic finish_op(input string tag, input logic [W-1:0] res, input logic z, input logic c, input logic v);
    tick();
    chk({tag, ".res"},  Result, res);
    chk({tag, ".zero"}, Zero, z);
    chk({tag, ".carry"}, Carry, c);
    chk({tag, ".ovf"},  Overflow, v);
    chk({tag, ".done"}, Done, 1'b1);
    chk({tag, ".busy"}, Busy, 1'b0);
    last_res = res;
    tick();
    chk({tag, ".done_clr"}, Done, 1'b0);
    chk({tag, ".res_hold"}, Result, res);
  endtask

  task automatic mul_wait(input string tag);
    for (int k = 1; k < W; k++) begin
      tick();
      chk({tag, ".busy_mid"}, Busy, 1'b1);
      chk({tag, ".done_mid"}, Done, 1'b0);
      chk({tag, ".hold_mid"}, Result, last_res);
    end
  endtask

  initial begin
    rst    = 1'b1;
    Start  = 1'b0;
    Op_sel = 3'b000;
    In_a   = '0;
    In_b   = '0;
    tick();
    tick();
    chk("rst.res",   Result, 6'd0);
    chk("rst.zero",  Zero, 1'b1);
    chk("rst.carry", Carry, 1'b0);
    chk("rst.ovf",   Overflow, 1'b0);
    chk("rst.busy",  Busy, 1'b0);
    chk("rst.done",  Done, 1'b0);

    // Reset wins over Start at the same edge.
    Start  = 1'b1;
    Op_sel = 3'b010;
    In_a   = 6'd25;
    In_b   = 6'd7;
    tick();
    chk("rst_ovr.busy", Busy, 1'b0);
    rst = 1'b0;

    issue("add25_7", 3'b010, 6'd25, 6'd7);
    finish_op("add25_7", 6'd32, 1'b0, 1'b0, 1'b1);
    issue("sub5_5", 3'b011, 6'd5, 6'd5);
    finish_op("sub5_5", 6'd0, 1'b1, 1'b0, 1'b0);
    issue("sub3_5", 3'b011, 6'd3, 6'd5);
    finish_op("sub3_5", 6'd62, 1'b0, 1'b1, 1'b0);
    issue("slt_m1_1", 3'b100, 6'd63, 6'd1);
    finish_op("slt_m1_1", 6'd1, 1'b0, 1'b0, 1'b0);
    issue("slt_1_m1", 3'b100, 6'd1, 6'd63);
    finish_op("slt_1_m1", 6'd0, 1'b1, 1'b0, 1'b0);
    issue("and", 3'b000, 6'd44, 6'd26);
    finish_op("and", 6'd8, 1'b0, 1'b0, 1'b0);
    issue("or", 3'b001, 6'd44, 6'd26);
    finish_op("or", 6'd62, 1'b0, 1'b0, 1'b0);
    issue("nor", 3'b110, 6'd44, 6'd26);
    finish_op("nor", 6'd1, 1'b0, 1'b0, 1'b0);
    issue("add63_1", 3'b010, 6'd63, 6'd1);
    finish_op("add63_1", 6'd0, 1'b1, 1'b1, 1'b0);
    issue("sub32_1", 3'b011, 6'd32, 6'd1);
    finish_op("sub32_1", 6'd31, 1'b0, 1'b0, 1'b1);
    issue("rsv12_3", 3'b111, 6'd12, 6'd3);
    finish_op("rsv12_3", 6'd0, 1'b1, 1'b0, 1'b0);

    // MUL 7*9 with Start pulses and changing operands while busy.
    issue("mul7_9", 3'b101, 6'd7, 6'd9);
    for (int k = 1; k < W; k++) begin
      Start  = 1'b1;
      Op_sel = 3'b010;
      In_a   = 6'd1;
      In_b   = 6'd1;
      tick();
      chk("mul7_9.busy_mid", Busy, 1'b1);
      chk("mul7_9.done_mid", Done, 1'b0);
      chk("mul7_9.hold_mid", Result, last_res);
    end
    Start = 1'b0;
    finish_op("mul7_9", 6'd63, 1'b0, 1'b0, 1'b0);
    chk("mul7_9.no_reissue", Busy, 1'b0);

    issue("mul9_8", 3'b101, 6'd9, 6'd8);
    mul_wait("mul9_8");
    finish_op("mul9_8", 6'd8, 1'b0, 1'b0, 1'b1);

    // Reset at edge N+3 of a multiply aborts it without a Done pulse.
    issue("mul_abort", 3'b101, 6'd7, 6'd9);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_res = '0;
    chk("abort.res",  Result, 6'd0);
    chk("abort.zero", Zero, 1'b1);
    chk("abort.busy", Busy, 1'b0);
    chk("abort.done", Done, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort.no_done", Done, 1'b0);
    end

    issue("add1_2", 3'b010, 6'd1, 6'd2);
    finish_op("add1_2", 6'd3, 1'b0, 1'b0, 1'b0);

    // Start held high: accepted every third edge.
    Start  = 1'b1;
    Op_sel = 3'b111;
    In_a   = 6'd12;
    In_b   = 6'd3;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("b2b.busy", Busy, (k % 3) == 0);
      chk("b2b.done", Done, (k % 3) == 1);
    end
    Start = 1'b0;
    chk("b2b.res",  Result, 6'd0);
    chk("b2b.zero", Zero, 1'b1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
